data_array_read_arbiter: RTL
============================

Name: data_array_read_arbiter

Overview:
- Shares the single read port of the reservation-station data array among NUM_REQ issue requesters using round-robin arbitration.
- Issues the array read, captures the 3 source operands returned one cycle later, and substitutes the immediate into operand 1 when requested. This is the immediate-extraction step.
- Delivers results through a 2-entry output buffer with a valid/ready handshake, so downstream stalls never drop data.

Parameters:
- NUM_REQ, 3, number of requesters.
- ADDR_W, 4, data array entry index width.
- DATA_W, 64, operand width.
- ID_W, 2, requester id width; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- io_req_valid  in  NUM_REQ  per-requester request valid.
- io_req_ready  out  NUM_REQ  one-hot grant; handshake when valid & ready.
- io_req_addr  in  NUM_REQ*ADDR_W  entry index; requester i occupies bits [i*ADDR_W +: ADDR_W].
- io_req_imm_en  in  NUM_REQ  substitute the immediate into operand 1.
- io_req_imm  in  NUM_REQ*DATA_W  immediate, already sign-extended.
- io_rd_en  out  1  array read enable.
- io_rd_addr  out  ADDR_W  array read index.
- io_rd_data_0/1/2  in  DATA_W each  array read data, valid the cycle after io_rd_en.
- io_resp_valid  out  1  response valid.
- io_resp_ready  in  1  downstream accepts.
- io_resp_id  out  ID_W  granted requester index.
- io_resp_data_0/1/2  out  DATA_W each  final operands.

Behaviour:
- Reset
  - Clears s1_valid, the output buffer (count 0) and all perf counters.
  - Sets rr_ptr = NUM_REQ-1, so requester 0 has highest priority first.
  - Output values during/after reset: io_req_ready=0, io_rd_en=0, io_resp_valid=0; io_resp_id and io_resp_data_* = 0.
  - Reset asserted mid-operation discards any in-flight read and all buffered responses.
- Arbitration (combinational, cycle t)
  - Candidates are valid requesters.
  - Search starts at (rr_ptr+1) mod NUM_REQ and wraps; the first valid requester wins.
  - A grant occurs only if can_issue = (count + s1_valid - deq) < 2, where deq = io_resp_valid & io_resp_ready this cycle.
  - On grant: io_req_ready[winner]=1; io_rd_en=1; io_rd_addr = winner's address; rr_ptr <= winner at the clock edge.
  - No grant leaves rr_ptr unchanged. io_req_ready never depends on io_req_valid of the same requester.
- Stage s1 (registered at grant)
  - Holds s1_valid, s1_id, s1_imm_en and s1_imm.
  - At t+1: op0 = io_rd_data_0; op1 = s1_imm_en ? s1_imm : io_rd_data_1; op2 = io_rd_data_2.
  - These operands are enqueued into the output buffer in the same cycle and are visible at io_resp_* from t+2.
  - Read-to-response latency: 2 cycles minimum.
- Output buffer
  - 2-entry FIFO; head drives io_resp_*.
  - Simultaneous enqueue and dequeue is legal: count unchanged, order preserved.
  - Enqueue into a full buffer is impossible by construction of can_issue; an assertion checks this.
- Throughput
  - One grant per cycle while io_resp_ready stays high.
  - With io_resp_ready low, at most 2 grants are outstanding in total (buffered plus in flight), after which io_req_ready stays 0.
- io_resp_data_* and io_resp_id hold their values while io_resp_valid & !io_resp_ready.

Optional Feature:
- Macro: DATA_ARRAY_READ_ARB_PERF_EN.
- Defined:
  - Adds 32-bit outputs io_perf_grant_cnt (increments per grant) and io_perf_stall_cnt (increments each cycle with any io_req_valid set but no grant).
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Single request, 1 cycle: req0 valid, addr=5, imm_en=0, ready held high -> io_rd_en=1 and io_rd_addr=5 at t; io_resp_valid at t+2 with id=0 and data = array entry 5 (op0/1/2).
- Immediate substitution: req1 addr=3, imm_en=1, imm=0xFFFF_FFFF_FFFF_FFF0 -> resp op1=0xFFFF_FFFF_FFFF_FFF0; op0 and op2 = entry 3 data.
- Round-robin fairness: all 3 valid continuously, ready=1 -> grant order 0,1,2,0,1,2 with one grant per cycle.
- Backpressure: all valid, ready=0 -> exactly 2 grants, then io_req_ready=0 and head stable; raising ready -> responses in grant order, grants resume the same cycle the first entry dequeues.
- Reset mid-flight: assert reset with 1 read in flight and 2 entries buffered -> next cycle io_resp_valid=0; first grant after reset goes to req0.
- Perf (macro defined): 3 valid, ready=0 for 10 cycles -> grant_cnt=2, stall_cnt=8.

Source files
------------

// File: rtl/data_array_read_arbiter.sv
// rtl/data_array_read_arbiter.sv - round-robin read-port arbiter with immediate substitution and 2-entry response buffer
// Optional macro DATA_ARRAY_READ_ARB_PERF_EN adds grant/stall performance counters.
module data_array_read_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        io_req_valid,
  output logic [NUM_REQ-1:0]        io_req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] io_req_addr,
  input  logic [NUM_REQ-1:0]        io_req_imm_en,
  input  logic [NUM_REQ*DATA_W-1:0] io_req_imm,
  output logic                      io_rd_en,
  output logic [ADDR_W-1:0]         io_rd_addr,
  input  logic [DATA_W-1:0]         io_rd_data_0,
  input  logic [DATA_W-1:0]         io_rd_data_1,
  input  logic [DATA_W-1:0]         io_rd_data_2,
  output logic                      io_resp_valid,
  input  logic                      io_resp_ready,
  output logic [ID_W-1:0]           io_resp_id,
  output logic [DATA_W-1:0]         io_resp_data_0,
  output logic [DATA_W-1:0]         io_resp_data_1,
  output logic [DATA_W-1:0]         io_resp_data_2
`ifdef DATA_ARRAY_READ_ARB_PERF_EN
  ,
  output logic [31:0]               io_perf_grant_cnt,
  output logic [31:0]               io_perf_stall_cnt
`endif
);

  logic [ID_W-1:0]   rr_ptr;
  logic              s1_valid;
  logic [ID_W-1:0]   s1_id;
  logic              s1_imm_en;
  logic [DATA_W-1:0] s1_imm;

  logic [DATA_W-1:0] buf_d0 [2];
  logic [DATA_W-1:0] buf_d1 [2];
  logic [DATA_W-1:0] buf_d2 [2];
  logic [ID_W-1:0]   buf_id [2];
  logic [1:0]        count;
  logic              rd_ptr;
  logic              wr_ptr;

  logic              deq;
  logic [2:0]        occ;
  logic              can_issue;
  logic              grant;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   idx;
  logic              blocked;
  logic [ADDR_W-1:0] win_addr;
  logic              win_imm_en;
  logic [DATA_W-1:0] win_imm;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
    logic [ID_W:0] s;
    s = {1'b0, base} + (ID_W+1)'(k);
    if (s >= (ID_W+1)'(NUM_REQ)) s = s - (ID_W+1)'(NUM_REQ);
    return s[ID_W-1:0];
  endfunction

  assign deq       = (count != 2'd0) && io_resp_ready;
  // Occupancy after this cycle's enqueue/dequeue; a new grant needs a free slot by then.
  assign occ       = {1'b0, count} + {2'b0, s1_valid} - {2'b0, deq};
  assign can_issue = (occ < 3'd2) && !reset;

  // A requester is offered the port when no earlier requester in search order is
  // valid, so its ready never looks at its own valid.
  always_comb begin
    io_req_ready = '0;
    grant        = 1'b0;
    winner       = '0;
    idx          = '0;
    blocked      = 1'b0;
    win_addr     = '0;
    win_imm_en   = 1'b0;
    win_imm      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = wrap_idx(rr_ptr, k);
      if (!blocked) begin
        io_req_ready[idx] = can_issue;
        if (io_req_valid[idx]) begin
          grant      = can_issue;
          winner     = idx;
          win_addr   = io_req_addr[int'(idx)*ADDR_W +: ADDR_W];
          win_imm_en = io_req_imm_en[idx];
          win_imm    = io_req_imm[int'(idx)*DATA_W +: DATA_W];
        end
      end
      blocked = blocked | io_req_valid[idx];
    end
  end

  assign io_rd_en   = grant;
  assign io_rd_addr = win_addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s1_imm_en <= 1'b0;
      s1_imm    <= '0;
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_d0[i] <= '0;
        buf_d1[i] <= '0;
        buf_d2[i] <= '0;
        buf_id[i] <= '0;
      end
    end else begin
      s1_valid <= grant;
      if (grant) begin
        rr_ptr    <= winner;
        s1_id     <= winner;
        s1_imm_en <= win_imm_en;
        s1_imm    <= win_imm;
      end
      // Array data arrives the cycle after the read; operand 1 may be replaced by the immediate.
      if (s1_valid) begin
        buf_d0[wr_ptr] <= io_rd_data_0;
        buf_d1[wr_ptr] <= s1_imm_en ? s1_imm : io_rd_data_1;
        buf_d2[wr_ptr] <= io_rd_data_2;
        buf_id[wr_ptr] <= s1_id;
        wr_ptr         <= ~wr_ptr;
      end
      if (deq) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, s1_valid} - {1'b0, deq};
    end
  end

  always @(posedge clock) begin
    if (!reset) assert (!(s1_valid && (count == 2'd2) && !deq));
  end

  assign io_resp_valid  = (count != 2'd0);
  assign io_resp_id     = buf_id[rd_ptr];
  assign io_resp_data_0 = buf_d0[rd_ptr];
  assign io_resp_data_1 = buf_d1[rd_ptr];
  assign io_resp_data_2 = buf_d2[rd_ptr];

`ifdef DATA_ARRAY_READ_ARB_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      io_perf_grant_cnt <= 32'd0;
      io_perf_stall_cnt <= 32'd0;
    end else if (grant) begin
      io_perf_grant_cnt <= io_perf_grant_cnt + 32'd1;
    end else if (|io_req_valid) begin
      io_perf_stall_cnt <= io_perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
